de2_switch_debouncer: RTL and testbench
=======================================

// Module: de2_switch_debouncer
// PURPOSE
//  Conditions the 18 raw DE2 toggle-switch inputs before they reach the toggles18 PIO in_port.
//  - Synchronises each switch into clk with two flops.
//  - Filters contact bounce: a bit changes only after a sustained run of mismatching samples.
//  - Emits a one-cycle change strobe per bit, so the downstream edge-capture logic sees exactly one edge per flip.
// PARAMETERS
//  WIDTH         18     number of switch bits
//  TICK_DIV      50000  clk cycles per sample tick (1 ms at 50 MHz); legal range >= 2
//  STABLE_TICKS  10     consecutive mismatching ticks required before the output flips; legal range >= 1
// PORTS
//  clk            in   1      system clock
//  reset_n        in   1      asynchronous active-low reset
//  raw_in         in   WIDTH  asynchronous switch pins SW[17:0]
//  debounced_out  out  WIDTH  filtered switch levels; drives PIO in_port
//  change_pulse   out  WIDTH  one-cycle high when the matching debounced_out bit flips
//  any_change     out  1      registered OR of change_pulse
//  tick           out  1      sample strobe, for observability
// BEHAVIOUR
//  - Clock and reset: single clock; reset is asynchronous and active-low.
//  - Reset values: every register is 0.
//    - Includes sync flops, prescaler, per-bit counters, debounced_out, change_pulse, any_change and tick.
//    - debounced_out = 0 on reset, so no spurious PIO edge is generated.
//  - Synchroniser: s1 <= raw_in; s2 <= s1. All filtering uses s2.
//  - Prescaler:
//    - width $clog2(TICK_DIV); counts 0..TICK_DIV-1, then wraps to 0.
//    - tick is registered and high for exactly 1 cycle per TICK_DIV cycles.
//  - Per-bit counter cnt[i]: width $clog2(STABLE_TICKS+1).
//    - s2[i] == debounced_out[i], any cycle: cnt <= 0, whether or not a tick is present.
//    - s2[i] != debounced_out[i], no tick: cnt holds.
//    - s2[i] != debounced_out[i], tick, cnt == STABLE_TICKS-1: debounced_out[i] <= s2[i]; cnt <= 0; change_pulse[i] <= 1.
//    - s2[i] != debounced_out[i], tick, otherwise: cnt <= cnt+1.
//  - change_pulse: defaults to 0 each cycle.
//    - It is asserted in the same cycle that debounced_out updates.
//  - any_change: registered one cycle after change_pulse.
//  - Latency from a raw edge to the output flip: between 2+(STABLE_TICKS-1)*TICK_DIV+1 and 2+STABLE_TICKS*TICK_DIV+1 cycles.
//  - Bounce: any return to agreement before the run completes clears the count.
//    - The output never toggles on a glitch shorter than (STABLE_TICKS-1)*TICK_DIV cycles.
//  - Bits are fully independent. Simultaneous flips on several bits in one cycle are all reported in the same cycle.
//  - Counters saturate by construction: they cannot exceed STABLE_TICKS-1, so no wrap-around is possible.
//  - Reset mid-count: everything returns to 0 immediately, asynchronously.
//    - After release the filter restarts from scratch.
//    - A switch held high is re-qualified in full before debounced_out rises.
//  - There is no bus interface and no software-visible state; all outputs are registered.
// STRUCTURE
//  - Shared package de2_io_pkg holds:
//    - DE2_SW_WIDTH = 18;
//    - DE2_DEBOUNCE_TICK_DIV and DE2_DEBOUNCE_STABLE_TICKS defaults;
//    - a clog2 helper.
//  - One sub-module, debounce_bit: sync pair + counter + output flop + pulse for one bit.
//    - It is instantiated WIDTH times via generate.
//    - It takes tick from the shared prescaler in the top level.
//  - The top level owns the prescaler, the tick register and the any_change OR-reduce.
//  - Elaboration-time check: fatal if TICK_DIV < 2 or STABLE_TICKS < 1.
// TESTING  (bench uses TICK_DIV=4, STABLE_TICKS=3)
//  1. Reset release, raw_in=0 -> tick high every 4th cycle exactly; all outputs 0; no change_pulse for 100 cycles.
//  2. raw_in[0] 0->1, held -> debounced_out[0]=1 within 11..15 cycles.
//     change_pulse[0] is high for exactly 1 cycle; any_change follows 1 cycle later; other bits stay 0.
//  3. raw_in[5] high for 7 cycles, then low -> debounced_out[5] stays 0; change_pulse never asserts.
//  4. Bounce: raw_in[9] toggles every 3 cycles for 30 cycles, then held 1 -> exactly one change_pulse[9].
//     debounced_out[9] ends at 1.
//  5. raw_in = 18'h3FFFF in one cycle -> all 18 bits flip in the same cycle; change_pulse = 18'h3FFFF for one cycle.
//     Then raw_in = 0 -> all bits return to 0, with a single pulse each.
//  6. raw_in[17]=1, reset_n pulsed low 8 cycles after the edge -> outputs 0 asynchronously.
//     After release, debounced_out[17] rises only after a full 11..15-cycle re-qualification.

Source files
------------

// File: rtl/de2_switch_debouncer_pkg.sv
// Shared DE2 I/O constants and elaboration-time helpers for the switch conditioning path.
package de2_io_pkg;

    localparam int DE2_SW_WIDTH              = 18;
    localparam int DE2_DEBOUNCE_TICK_DIV     = 50000;
    localparam int DE2_DEBOUNCE_STABLE_TICKS = 10;

    // Ceiling log2 of value; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        for (int k = 0; k < 32; k++) begin
            if (v > 0) begin
                result = result + 1;
                v      = v >>> 1;
            end
        end
        return result;
    endfunction

    // Register width for a counter covering 0..count-1, never narrower than one bit.
    function automatic int cnt_width(input int count);
        int w;
        w = clog2(count);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/de2_switch_debouncer_debounce_bit.sv
// One switch bit: two-flop synchroniser, mismatch-run counter, filtered level and change strobe.
module debounce_bit
    import de2_io_pkg::*;
#(
    parameter int STABLE_TICKS = DE2_DEBOUNCE_STABLE_TICKS
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic pulse
);

    localparam int            CW       = cnt_width(STABLE_TICKS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          pulse_q, pulse_d;

    // Next-state: any agreement clears the run; a run of STABLE_TICKS mismatching ticks flips the level.
    always_comb begin
        s1_d    = raw;
        s2_d    = s1_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        pulse_d = 1'b0;
        if (s2_q == level_q) begin
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_q == CNT_LAST) begin
                level_d = s2_q;
                cnt_d   = '0;
                pulse_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers, all cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    assign level = level_q;
    assign pulse = pulse_q;

endmodule

// File: rtl/de2_switch_debouncer.sv
// DE2 toggle-switch conditioner: shared sample prescaler feeding WIDTH independent debounce filters.
module de2_switch_debouncer
    import de2_io_pkg::*;
#(
    parameter int WIDTH        = DE2_SW_WIDTH,
    parameter int TICK_DIV     = DE2_DEBOUNCE_TICK_DIV,
    parameter int STABLE_TICKS = DE2_DEBOUNCE_STABLE_TICKS
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] debounced_out,
    output logic [WIDTH-1:0] change_pulse,
    output logic             any_change,
    output logic             tick
);

    localparam int            PW         = cnt_width(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    generate
        if (TICK_DIV < 2) begin : g_bad_div
            $fatal(1, "de2_switch_debouncer: TICK_DIV must be >= 2");
        end
        if (STABLE_TICKS < 1) begin : g_bad_stable
            $fatal(1, "de2_switch_debouncer: STABLE_TICKS must be >= 1");
        end
    endgenerate

    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;
    logic          any_change_q, any_change_d;

    // Prescaler wraps at TICK_DIV-1; the tick is registered from the wrap so it is a clean 1-cycle strobe.
    always_comb begin
        presc_d      = presc_q + 1'b1;
        tick_d       = 1'b0;
        any_change_d = |change_pulse;
        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            tick_d  = 1'b1;
        end
    end

    // Prescaler, tick and summary-strobe registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q      <= '0;
            tick_q       <= 1'b0;
            any_change_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            tick_q       <= tick_d;
            any_change_q <= any_change_d;
        end
    end

    assign tick       = tick_q;
    assign any_change = any_change_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_bit (
            .clk    (clk),
            .reset_n(reset_n),
            .tick   (tick_q),
            .raw    (raw_in[i]),
            .level  (debounced_out[i]),
            .pulse  (change_pulse[i])
        );
    end

endmodule

// File: tb/tb_de2_switch_debouncer.sv
// Self-checking bench: behavioural filter model compared every cycle, plus directed literal checks.
module tb_de2_switch_debouncer;

    localparam int W  = 18;
    localparam int TD = 4;
    localparam int ST = 3;
    localparam logic [W-1:0] ALL1 = 18'h3FFFF;

    logic         clk;
    logic         reset_n;
    logic [W-1:0] raw_in;
    logic [W-1:0] debounced_out;
    logic [W-1:0] change_pulse;
    logic         any_change;
    logic         tick;

    int n_assert;
    int n_fail;

    de2_switch_debouncer #(
        .WIDTH       (W),
        .TICK_DIV    (TD),
        .STABLE_TICKS(ST)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .raw_in       (raw_in),
        .debounced_out(debounced_out),
        .change_pulse (change_pulse),
        .any_change   (any_change),
        .tick         (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: raw seen two edges late, sample every TD-th edge since release,
    // level flips after ST consecutive sampled disagreements, any agreement restarts the run.
    logic [W-1:0] m_hist1, m_hist2, m_level, m_pulse;
    logic         m_any, m_tick;
    int           m_edges;
    int           m_run [W];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_hist1 = '0; m_hist2 = '0; m_level = '0; m_pulse = '0;
            m_any = 1'b0; m_tick = 1'b0; m_edges = 0;
            for (int i = 0; i < W; i++) m_run[i] = 0;
        end else begin
            logic [W-1:0] new_pulse;
            new_pulse = '0;
            m_any = |m_pulse;
            for (int i = 0; i < W; i++) begin
                if (m_hist2[i] == m_level[i]) begin
                    m_run[i] = 0;
                end else if (m_tick) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == ST) begin
                        m_level[i]   = m_hist2[i];
                        new_pulse[i] = 1'b1;
                        m_run[i]     = 0;
                    end
                end
            end
            m_pulse = new_pulse;
            m_hist2 = m_hist1;
            m_hist1 = raw_in;
            m_edges = m_edges + 1;
            m_tick  = (m_edges % TD) == 0;
        end
    end

    // Every-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        chk("model_debounced", 64'(debounced_out), 64'(m_level));
        chk("model_pulse",     64'(change_pulse),  64'(m_pulse));
        chk("model_any",       64'(any_change),    64'(m_any));
        chk("model_tick",      64'(tick),          64'(m_tick));
    end

    // Running per-bit pulse tallies.
    int ptally [W];
    initial for (int i = 0; i < W; i++) ptally[i] = 0;
    always @(negedge clk) begin
        if (reset_n) begin
            for (int i = 0; i < W; i++) if (change_pulse[i]) ptally[i] = ptally[i] + 1;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Counts posedges until debounced_out[idx] is seen high, bounded at 40.
    task automatic wait_rise(input int idx, output int n, output bit seen);
        n = 0; seen = 0;
        while (!seen && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (debounced_out[idx]) seen = 1;
        end
    endtask

    initial begin
        int  n, ticks, first_tick, snap, snap9, bad;
        bit  seen;
        int  snaps [W];
        n_assert = 0; n_fail = 0;
        reset_n = 1'b0; raw_in = '0;
        #1;
        chk("reset_debounced", 64'(debounced_out), 64'd0);
        chk("reset_tick",      64'(tick),          64'd0);
        step(3);
        reset_n = 1'b1;

        // 1: tick cadence and quiet outputs.
        ticks = 0; first_tick = 0; snap = ptally[0];
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            if (tick) begin
                ticks++;
                if (first_tick == 0) first_tick = c;
            end
        end
        #1;
        chk("t1_tick_count", 64'(ticks), 64'd25);
        chk("t1_first_tick", 64'(first_tick), 64'd4);
        chk("t1_quiet", 64'(debounced_out | change_pulse), 64'd0);

        // 2: single clean rise on bit 0.
        snap = ptally[0];
        raw_in[0] = 1'b1;
        wait_rise(0, n, seen);
        chk("t2_seen", 64'(seen), 64'd1);
        chk("t2_latency_ok", 64'(n >= 11 && n <= 15), 64'd1);
        chk("t2_pulse_at_flip", 64'(change_pulse), 64'd1);
        chk("t2_any_not_yet", 64'(any_change), 64'd0);
        @(posedge clk); #1;
        chk("t2_pulse_gone", 64'(change_pulse), 64'd0);
        chk("t2_any_follows", 64'(any_change), 64'd1);
        step(20);
        chk("t2_one_pulse", 64'(ptally[0] - snap), 64'd1);
        chk("t2_other_bits", 64'(debounced_out), 64'd1);

        // 3: 7-cycle glitch on bit 5 is rejected.
        snap = ptally[5];
        raw_in[5] = 1'b1; step(7);
        raw_in[5] = 1'b0; step(30);
        chk("t3_no_pulse", 64'(ptally[5] - snap), 64'd0);
        chk("t3_level", 64'(debounced_out[5]), 64'd0);

        // 4: bounce on bit 9 then settle high.
        snap9 = ptally[9];
        for (int k = 0; k < 10; k++) begin
            raw_in[9] = ~raw_in[9]; step(3);
        end
        raw_in[9] = 1'b1; step(40);
        chk("t4_one_pulse", 64'(ptally[9] - snap9), 64'd1);
        chk("t4_level", 64'(debounced_out[9]), 64'd1);

        // 5: all bits at once, then all back.
        raw_in = '0; step(40);
        chk("t5_cleared", 64'(debounced_out), 64'd0);
        for (int i = 0; i < W; i++) snaps[i] = ptally[i];
        raw_in = ALL1;
        wait_rise(17, n, seen);
        chk("t5_seen", 64'(seen), 64'd1);
        chk("t5_all_flip", 64'(debounced_out), 64'(ALL1));
        chk("t5_all_pulse", 64'(change_pulse), 64'(ALL1));
        @(posedge clk); #1;
        chk("t5_pulse_single", 64'(change_pulse), 64'd0);
        raw_in = '0; step(40);
        chk("t5_back_low", 64'(debounced_out), 64'd0);
        bad = 0;
        for (int i = 0; i < W; i++) if (ptally[i] - snaps[i] != 2) bad++;
        chk("t5_two_pulses_each", 64'(bad), 64'd0);

        // 6: async reset mid-qualification on bit 17 with bit 3 already high.
        raw_in[3] = 1'b1; step(40);
        chk("t6_bit3_up", 64'(debounced_out[3]), 64'd1);
        raw_in[17] = 1'b1; step(8);
        reset_n = 1'b0; #1;
        chk("t6_async_clear", 64'(debounced_out | change_pulse), 64'd0);
        chk("t6_async_any_tick", 64'({any_change, tick}), 64'd0);
        step(3);
        reset_n = 1'b1;
        wait_rise(17, n, seen);
        chk("t6_seen", 64'(seen), 64'd1);
        chk("t6_requal_ok", 64'(n >= 11 && n <= 15), 64'd1);

        // Randomised bounce/settle traffic checked by the model process.
        for (int c = 0; c < 3000; c++) begin
            logic [W-1:0] m;
            if ((c / 200) % 2 == 0)
                m = W'($urandom & $urandom & $urandom & $urandom);
            else
                m = W'($urandom & $urandom & $urandom & $urandom & $urandom & $urandom);
            raw_in = raw_in ^ m;
            if ($urandom_range(0, 999) == 0) begin
                reset_n = 1'b0; step(2); reset_n = 1'b1;
            end
            step(1);
        end
        step(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
